// File: rtl/ula_seq_pkg.sv
// Shared definitions for the sequential ALU: operation codes and controller state encoding.
package ula_seq_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/ula_comb.sv
// Single-cycle ALU slice: AND/OR/ADD/SUB/SLT/NOR with signed overflow and carry out.
module ula_comb
    import ula_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry_out
);

    logic             b_negate;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] low_sum;
    logic [WIDTH:0]   sum;
    logic             carry_msb;
    logic             add_ovf;
    logic             set;

    // One adder serves ADD, SUB and SLT; Bnegate doubles as the carry-in.
    assign b_negate  = op[2];
    assign b_sel     = b_negate ? ~b : b;
    assign low_sum   = {1'b0, a[WIDTH-2:0]} + {1'b0, b_sel[WIDTH-2:0]}
                     + {{(WIDTH-1){1'b0}}, b_negate};
    assign sum       = {1'b0, a} + {1'b0, b_sel} + {{WIDTH{1'b0}}, b_negate};
    assign carry_msb = low_sum[WIDTH-1];
    assign add_ovf   = carry_msb ^ sum[WIDTH];
    assign set       = sum[WIDTH-1] ^ add_ovf;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result    = '0;
        overflow  = 1'b0;
        carry_out = 1'b0;
        unique case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_NOR: result = ~(a | b);
            OP_ADD, OP_SUB: begin
                result    = sum[WIDTH-1:0];
                overflow  = add_ovf;
                carry_out = sum[WIDTH];
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, set};
            default: ;
        endcase
    end

endmodule

// File: rtl/ula_seq.sv
// Handshaked ALU: single-cycle ops via ula_comb, WIDTH-cycle shift-and-add multiply, output register.
module ula_seq
    import ula_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   comb_result;
    logic               comb_ovf;
    logic               comb_carry;
    logic               accept;
    logic               is_mul;
    logic               mul_done;

    ula_comb #(.WIDTH(WIDTH)) u_comb (
        .a         (a),
        .b         (b),
        .op        (op),
        .result    (comb_result),
        .overflow  (comb_ovf),
        .carry_out (comb_carry)
    );

    assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OP_MUL);
    assign mul_done  = (state == ST_BUSY) && (cnt == CW'(1));
    assign acc_nxt   = mplier[0] ? acc + mcand : acc;
    assign out_valid = (state == ST_HOLD);
    assign zero      = out_valid && (result == '0);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_HOLD: begin
                if (accept)
                    state_nxt = is_mul ? ST_BUSY : ST_HOLD;
                else if ((state == ST_HOLD) && out_ready)
                    state_nxt = ST_IDLE;
            end
            ST_BUSY: if (cnt == CW'(1)) state_nxt = ST_HOLD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: the datapath is reset as well, because result and flags must read 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            if (accept && is_mul) begin
                cnt    <= CW'(WIDTH);
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
            end else if (state == ST_BUSY) begin
                cnt    <= cnt - CW'(1);
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end

            // The last partial product is folded in on the same edge that enters HOLD.
            if (accept && !is_mul) begin
                result    <= comb_result;
                overflow  <= comb_ovf;
                carry_out <= comb_carry;
            end else if (mul_done) begin
                result    <= acc_nxt[WIDTH-1:0];
                overflow  <= |acc_nxt[2*WIDTH-1:WIDTH];
                carry_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Directed self-checking bench for ula_seq at WIDTH=8 with hand-computed expected values.
module tb_ula_seq;
    import ula_seq_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    int checks = 0;
    int errors = 0;

    ula_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [WIDTH-1:0] r,
                             input logic z, input logic ov, input logic co);
        check({tag, ".valid"}, 64'(out_valid), 64'(1));
        check({tag, ".result"}, 64'(result), 64'(r));
        check({tag, ".zero"}, 64'(zero), 64'(z));
        check({tag, ".overflow"}, 64'(overflow), 64'(ov));
        check({tag, ".carry"}, 64'(carry_out), 64'(co));
    endtask

    // Issues a MUL, presents a decoy request while busy, and measures latency to out_valid.
    task automatic run_mul(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic [WIDTH-1:0] r, input logic z, input logic ov);
        int lat;
        send(OP_MUL, x, y);
        op       = OP_ADD;
        a        = 8'h01;
        b        = 8'h01;
        in_valid = 1'b1;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            check({tag, ".busy_in_ready"}, 64'(in_ready), 64'(0));
            step();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, 64'(lat), 64'(WIDTH));
        check_out(tag, r, z, ov, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        step();
        step();
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.result", 64'(result), 64'(0));
        check("rst.zero", 64'(zero), 64'(0));
        check("rst.overflow", 64'(overflow), 64'(0));
        check("rst.carry", 64'(carry_out), 64'(0));
        check("rst.in_ready", 64'(in_ready), 64'(1));
        reset = 1'b0;

        // Signed overflow on ADD, held while the consumer stalls.
        send(OP_ADD, 8'h7F, 8'h01);
        check_out("add_ovf", 8'h80, 1'b0, 1'b1, 1'b0);
        check("add_ovf.hold_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        #1;
        check("add_ovf.release_in_ready", 64'(in_ready), 64'(1));
        step();
        check("add_ovf.drained", 64'(out_valid), 64'(0));

        send(OP_ADD, 8'hFF, 8'h01);
        check_out("add_carry", 8'h00, 1'b1, 1'b0, 1'b1);
        send(OP_SUB, 8'h05, 8'h05);
        check_out("sub_eq", 8'h00, 1'b1, 1'b0, 1'b1);
        send(OP_SLT, 8'h80, 8'h01);
        check_out("slt_neg", 8'h01, 1'b0, 1'b0, 1'b0);
        send(4'b1111, 8'hFF, 8'hFF);
        check_out("bad_op", 8'h00, 1'b1, 1'b0, 1'b0);
        step();

        // Multiply with the consumer stalled: result must hold for three cycles.
        out_ready = 1'b0;
        run_mul("mul_0c_0b", 8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mul_hold.valid", 64'(out_valid), 64'(1));
            check("mul_hold.result", 64'(result), 64'(8'h84));
            check("mul_hold.in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        step();
        check("mul_hold.drained", 64'(out_valid), 64'(0));

        run_mul("mul_ovf", 8'h20, 8'h10, 8'h00, 1'b1, 1'b1);
        step();

        // Back-to-back single-cycle ops with out_ready held high.
        send(OP_ADD, 8'h10, 8'h22);
        check_out("b2b_add", 8'h32, 1'b0, 1'b0, 1'b0);
        send(OP_OR, 8'hA0, 8'h05);
        check_out("b2b_or", 8'hA5, 1'b0, 1'b0, 1'b0);
        send(OP_NOR, 8'hA0, 8'h05);
        check_out("b2b_nor", 8'h5A, 1'b0, 1'b0, 1'b0);
        send(OP_AND, 8'hF0, 8'h3C);
        check_out("b2b_and", 8'h30, 1'b0, 1'b0, 1'b0);
        step();
        check("b2b.drained", 64'(out_valid), 64'(0));

        // Reset three cycles into a multiply.
        send(OP_MUL, 8'h0C, 8'h0B);
        step();
        step();
        check("rst_mul.busy_in_ready", 64'(in_ready), 64'(0));
        reset = 1'b1;
        #1;
        check("rst_mul.out_valid", 64'(out_valid), 64'(0));
        check("rst_mul.in_ready", 64'(in_ready), 64'(1));
        step();
        reset = 1'b0;
        check("rst_mul.after_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b0;
        send(OP_ADD, 8'h01, 8'h02);
        check_out("rst_mul.add", 8'h03, 1'b0, 1'b0, 1'b0);

        // Reset while holding a result clears it asynchronously.
        reset = 1'b1;
        #1;
        check("rst_hold.out_valid", 64'(out_valid), 64'(0));
        check("rst_hold.result", 64'(result), 64'(0));
        check("rst_hold.zero", 64'(zero), 64'(0));
        step();
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 a  input  WIDTH  operand A, two's complement.
REQ-007 b  input  WIDTH  operand B, two's complement.
REQ-008 op  input  4  {Ainvert, Bnegate, operation[1:0]}.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  result == 0.
REQ-013 overflow  output  1  signed overflow (ADD/SUB); product exceeds WIDTH bits (MUL); else 0.
REQ-014 carry_out  output  1  carry out of MSB (ADD/SUB, SUB carry = no borrow); else 0.

Function
REQ-015 Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 SLT, 1100 NOR, 0011 MUL; any other code yields result 0, zero 1, overflow 0, carry_out 0.
REQ-016 ADD/SUB computed as a + (Bnegate ? ~b : b) + Bnegate over WIDTH bits; overflow = carry into MSB XOR carry out of MSB.
REQ-017 SLT result = {WIDTH-1 zeros, set}, set = MSB of a-b XOR overflow of a-b; reported overflow and carry_out are 0.
REQ-018 MUL: unsigned shift-and-add, one partial product per cycle, result = low WIDTH bits of a*b.
REQ-019 Request accepted on a rising edge where in_valid and in_ready are both 1; operands and op captured at that edge.
REQ-020 States: IDLE (output empty), BUSY (MUL iterating), HOLD (out_valid=1).
REQ-021 IDLE: in_ready=1; accepted non-MUL -> HOLD with result registered (latency 1 cycle); accepted MUL -> BUSY, iteration counter = WIDTH.
REQ-022 BUSY: in_ready=0; counter decrements each cycle; at counter 1 -> HOLD next edge, so MUL out_valid rises WIDTH cycles after acceptance.
REQ-023 HOLD: result/flags stable while out_ready=0; out_ready=1 and in_valid=0 -> IDLE; out_ready=1 with acceptance -> new op handled as from IDLE (back-to-back, no bubble).
REQ-024 in_ready = (state==IDLE) or (state==HOLD and out_ready); combinational from out_ready only, no in_valid->in_ready path.
REQ-025 in_valid, a, b, op ignored when in_ready=0; no request dropped, none duplicated.
REQ-026 zero derived from registered result, valid only when out_valid=1.

Reset
REQ-027 reset=1 forces state IDLE, out_valid 0, result 0, zero 0, overflow 0, carry_out 0, counter 0, asynchronously.
REQ-028 reset mid-MUL or mid-HOLD discards the operation; first acceptance possible on first clk edge after reset deasserts.

Structure
REQ-029 Shared package holds op code constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL) and state encoding.
REQ-030 One sub-module ula_comb (WIDTH-parametrised combinational AND/OR/ADD/SUB/SLT/NOR with overflow, carry_out, set); ula_seq adds handshake, MUL datapath and output register.

Verification (WIDTH=8)
REQ-031 ADD a=0x7F b=0x01 -> one cycle later result 0x80, overflow 1, carry_out 0, zero 0.
REQ-032 SUB a=0x05 b=0x05 -> result 0x00, zero 1, carry_out 1, overflow 0; SLT a=0x80 b=0x01 -> result 0x01.
REQ-033 MUL a=0x0C b=0x0B -> out_valid 8 cycles after acceptance, result 0x84, overflow 0, in_ready 0 throughout BUSY; MUL 0x20*0x10 -> result 0x00, overflow 1, zero 1.
REQ-034 Back-to-back ADD,OR,NOR with out_ready=1 -> one result per cycle, in order; out_ready=0 for 3 cycles -> result held, in_ready 0.
REQ-035 Assert reset 3 cycles into MUL -> out_valid 0 immediately, in_ready 1 after deassertion, next ADD 0x01+0x02 -> 0x03.
REQ-036 Op 1111 a=0xFF b=0xFF -> result 0x00, zero 1, overflow 0, carry_out 0.
